// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: load/store unit with a req/ack data-memory port,
// byte lanes, load extension, misalignment detection and valid/stall/flush.
module rv32i_mem_stage #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int BE_W  = XLEN / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  iw_in,
    input  logic [XLEN-1:0]  alu_in,
    input  logic [XLEN-1:0]  rs1_data_in,
    input  logic [XLEN-1:0]  rs2_data_in,
    input  logic [REG_W-1:0] wb_reg_in,
    input  logic             wb_en_in,
    output logic             stall_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [BE_W-1:0]  dmem_be,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             valid_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  iw_out,
    output logic [XLEN-1:0]  alu_out,
    output logic [XLEN-1:0]  rs1_data_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [REG_W-1:0] wb_reg_out,
    output logic             wb_en_out,
    output logic             misalign_out
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("rv32i_mem_stage supports XLEN=32 only");
    end

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  iw;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [REG_W-1:0] wb_reg;
        logic             wb_en;
    } bundle_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic            kill_q, kill_d;
    bundle_t         cap_q, cap_d;
    bundle_t         out_q, out_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    bundle_t         in_b;
    logic [2:0]      f3;
    logic            is_load, is_store, is_mem, misalign;
    logic [BE_W-1:0] be_in;
    logic [XLEN-1:0] wd_in;
    logic [2:0]      cap_f3;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_res;
    logic            killed;

    assign in_b = '{pc: pc_in, iw: iw_in, alu: alu_in,
                    rs1: rs1_data_in, rs2: rs2_data_in,
                    wb_reg: wb_reg_in, wb_en: wb_en_in};

    always_comb begin
        f3       = iw_in[14:12];
        is_load  = (iw_in[6:0] == 7'b0000011) &&
                   (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store = (iw_in[6:0] == 7'b0100011) &&
                   (f3 inside {3'b000, 3'b001, 3'b010});
        is_mem   = is_load || is_store;
        misalign = is_mem &&
                   (((f3[1:0] == 2'b01) && alu_in[0]) ||
                    ((f3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00)));
        be_in = BE_W'(4'b1111);
        wd_in = rs2_data_in;
        unique case (1'b1)
            (f3[1:0] == 2'b00): begin
                be_in = BE_W'(1) << alu_in[1:0];
                wd_in = {4{rs2_data_in[7:0]}};
            end
            (f3[1:0] == 2'b01): begin
                be_in = alu_in[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
                wd_in = {2{rs2_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the captured address; the upstream copy may change.
    always_comb begin
        cap_f3 = cap_q.iw[14:12];
        ld_b   = dmem_rdata[7:0];
        unique case (cap_q.alu[1:0])
            2'b00: ld_b = dmem_rdata[7:0];
            2'b01: ld_b = dmem_rdata[15:8];
            2'b10: ld_b = dmem_rdata[23:16];
            2'b11: ld_b = dmem_rdata[31:24];
        endcase
        ld_h = cap_q.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (cap_f3)
            3'b000:  ld_res = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_res = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_res = {24'b0, ld_b};
            3'b101:  ld_res = {16'b0, ld_h};
            default: ld_res = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        cap_d   = cap_q;
        out_d   = out_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        killed  = kill_q || flush;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d     = 1'b0;
                    out_d.wb_en = 1'b0;
                    mis_d       = 1'b0;
                end else if (valid_in && is_mem && !misalign) begin
                    cap_d   = in_b;
                    state_d = WAIT;
                    kill_d  = 1'b0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {alu_in[XLEN-1:2], 2'b00};
                    be_d    = be_in;
                    wdata_d = wd_in;
                    valid_d = 1'b0;
                end else if (valid_in) begin
                    out_d       = in_b;
                    out_d.wb_en = wb_en_in && !misalign;
                    mis_d       = misalign;
                    valid_d     = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            WAIT: begin
                kill_d = killed;
                if (dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
                    out_d   = cap_q;
                    if (!cap_q.iw[5]) out_d.alu = ld_res;
                    out_d.wb_en = cap_q.wb_en && !killed;
                    valid_d = !killed;
                    mis_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            cap_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign stall_out    = (state_q == WAIT);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign valid_out    = valid_q;
    assign pc_out       = out_q.pc;
    assign iw_out       = out_q.iw;
    assign alu_out      = out_q.alu;
    assign rs1_data_out = out_q.rs1;
    assign rs2_data_out = out_q.rs2;
    assign wb_reg_out   = out_q.wb_reg;
    assign wb_en_out    = out_q.wb_en;
    assign misalign_out = mis_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Directed bench for rv32i_mem_stage; writeback results are checked
// against a queue of expected results filled as instructions are issued.
module tb_rv32i_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0, iw_in = '0, alu_in = '0;
    logic [31:0] rs1_data_in = '0, rs2_data_in = '0;
    logic [4:0]  wb_reg_in = '0;
    logic        wb_en_in = 1'b0;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        valid_out, wb_en_out, misalign_out;
    logic [31:0] pc_out, iw_out, alu_out, rs1_data_out, rs2_data_out;
    logic [4:0]  wb_reg_out;

    rv32i_mem_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
        .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_out(valid_out), .pc_out(pc_out), .iw_out(iw_out),
        .alu_out(alu_out), .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out), .wb_reg_out(wb_reg_out),
        .wb_en_out(wb_en_out), .misalign_out(misalign_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic        wb_en;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && valid_out) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL wb_unexpected: observed valid pc %h expected none",
                       pc_out);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("wb_pc", pc_out, mon_e.pc);
                chk("wb_alu", alu_out, mon_e.alu);
                chk("wb_en", {31'b0, wb_en_out}, {31'b0, mon_e.wb_en});
                chk("wb_mis", {31'b0, misalign_out}, {31'b0, mon_e.mis});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] iw,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic we);
        valid_in    = 1'b1;
        pc_in       = pc;
        iw_in       = iw;
        alu_in      = alu;
        rs1_data_in = 32'h1111_0000 ^ pc;
        rs2_data_in = rs2;
        wb_reg_in   = rd;
        wb_en_in    = we;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] alu,
                        input logic we, input logic mis);
        exp_t e;
        e = '{pc: pc, alu: alu, wb_en: we, mis: mis};
        sb.push_back(e);
    endtask

    // Called one tick after the capture edge; ack lands in cycle dly-1.
    task automatic mem_wait(input int dly, input int flush_at,
                            input logic [31:0] rd, input string tag);
        int st = 0;
        int rq = 0;
        for (int i = 0; i < dly; i++) begin
            if (stall_out) st++;
            if (dmem_req) rq++;
            flush      = (i == flush_at);
            dmem_ack   = (i == dly - 1);
            dmem_rdata = (i == dly - 1) ? rd : 32'hDEAD_BEEF;
            cyc();
        end
        flush    = 1'b0;
        dmem_ack = 1'b0;
        valid_in = 1'b0;
        chk({tag, "_stall_cycles"}, st, dly);
        chk({tag, "_req_cycles"}, rq, dly);
        chk({tag, "_stall_after"}, {31'b0, stall_out}, 32'd0);
        chk({tag, "_req_after"}, {31'b0, dmem_req}, 32'd0);
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_wb_en", {31'b0, wb_en_out}, 32'd0);
        chk("rst_mis", {31'b0, misalign_out}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall_out}, 32'd0);
        chk("rst_alu", alu_out, 32'd0);
        reset = 1'b1;
        cyc();

        drive(32'h1000, 32'h0000_0033, 32'h1234, 32'h0, 5'd5, 1'b1);
        push(32'h1000, 32'h1234, 1'b1, 1'b0);
        cyc();
        chk("add_valid", {31'b0, valid_out}, 32'd1);
        chk("add_req", {31'b0, dmem_req}, 32'd0);
        chk("add_stall", {31'b0, stall_out}, 32'd0);
        valid_in = 1'b0;
        cyc();
        chk("idle_valid", {31'b0, valid_out}, 32'd0);
        chk("idle_alu_hold", alu_out, 32'h1234);

        drive(32'h1004, 32'h0000_0083, 32'h103, 32'h0, 5'd1, 1'b1);
        push(32'h1004, 32'hFFFF_FF80, 1'b1, 1'b0);
        cyc();
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", {31'b0, dmem_we}, 32'd0);
        chk("lb_be", {28'b0, dmem_be}, 32'h8);
        chk("lb_bubble", {31'b0, valid_out}, 32'd0);
        mem_wait(3, -1, 32'h80FF_FF00, "lb");

        drive(32'h1008, 32'h0000_4083, 32'h103, 32'h0, 5'd2, 1'b1);
        push(32'h1008, 32'h0000_0080, 1'b1, 1'b0);
        cyc();
        mem_wait(3, -1, 32'h80FF_FF00, "lbu");

        drive(32'h100C, 32'h0000_1023, 32'h202, 32'hABCD_1234, 5'd0, 1'b0);
        push(32'h100C, 32'h202, 1'b0, 1'b0);
        cyc();
        chk("sh_we", {31'b0, dmem_we}, 32'd1);
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        chk("sh_addr", dmem_addr, 32'h200);
        mem_wait(1, -1, 32'h0, "sh");

        drive(32'h1010, 32'h0000_2083, 32'h301, 32'h0, 5'd3, 1'b1);
        push(32'h1010, 32'h301, 1'b0, 1'b1);
        cyc();
        chk("lwmis_req", {31'b0, dmem_req}, 32'd0);
        chk("lwmis_stall", {31'b0, stall_out}, 32'd0);
        chk("lwmis_valid", {31'b0, valid_out}, 32'd1);
        valid_in = 1'b0;

        drive(32'h1014, 32'h0000_0023, 32'h501, 32'h0000_0077, 5'd0, 1'b0);
        push(32'h1014, 32'h501, 1'b0, 1'b0);
        cyc();
        chk("sb_be", {28'b0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h7777_7777);
        chk("sb_addr", dmem_addr, 32'h500);
        mem_wait(2, -1, 32'h0, "sb");

        drive(32'h1018, 32'h0000_1083, 32'h502, 32'h0, 5'd4, 1'b1);
        push(32'h1018, 32'hFFFF_8001, 1'b1, 1'b0);
        cyc();
        chk("lh_be", {28'b0, dmem_be}, 32'hC);
        mem_wait(1, -1, 32'h8001_1234, "lh");

        drive(32'h101C, 32'h0000_5083, 32'h500, 32'h0, 5'd6, 1'b1);
        push(32'h101C, 32'h0000_9234, 1'b1, 1'b0);
        cyc();
        mem_wait(2, -1, 32'h8001_9234, "lhu");

        drive(32'h1020, 32'h0000_2083, 32'h400, 32'h0, 5'd7, 1'b1);
        cyc();
        chk("lwk_req", {31'b0, dmem_req}, 32'd1);
        mem_wait(4, 1, 32'h5555_5555, "lwk");
        chk("lwk_valid", {31'b0, valid_out}, 32'd0);
        chk("lwk_wb_en", {31'b0, wb_en_out}, 32'd0);

        drive(32'h1024, 32'h0000_2023, 32'h404, 32'h9999_0000, 5'd0, 1'b0);
        cyc();
        mem_wait(2, 1, 32'h0, "swk");
        chk("swk_valid", {31'b0, valid_out}, 32'd0);

        drive(32'h1028, 32'h0000_2023, 32'h408, 32'h1, 5'd0, 1'b0);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        valid_in = 1'b0;
        chk("fidle_req", {31'b0, dmem_req}, 32'd0);
        chk("fidle_stall", {31'b0, stall_out}, 32'd0);
        chk("fidle_valid", {31'b0, valid_out}, 32'd0);
        chk("fidle_wb_en", {31'b0, wb_en_out}, 32'd0);

        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        cyc();
        dmem_ack = 1'b0;
        chk("ackidle_valid", {31'b0, valid_out}, 32'd0);
        chk("ackidle_stall", {31'b0, stall_out}, 32'd0);

        drive(32'h102C, 32'h0000_2083, 32'h600, 32'h0, 5'd8, 1'b1);
        cyc();
        chk("rstw_req_pre", {31'b0, dmem_req}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rstw_req", {31'b0, dmem_req}, 32'd0);
        chk("rstw_stall", {31'b0, stall_out}, 32'd0);
        chk("rstw_valid", {31'b0, valid_out}, 32'd0);
        valid_in = 1'b0;
        cyc();
        reset = 1'b1;
        drive(32'h2000, 32'h0000_0033, 32'h5678, 32'h0, 5'd9, 1'b1);
        push(32'h2000, 32'h5678, 1'b1, 1'b0);
        cyc();
        chk("post_rst_valid", {31'b0, valid_out}, 32'd1);
        valid_in = 1'b0;

        repeat (3) cyc();
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
